// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic library (serial add/sub, divider).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   arith_state_e : start/run/done FSM encoding shared by the sequential units.
package arith_pkg;

    // Common three-state sequencing used by every bit-serial unit in the library.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } arith_state_e;

endpackage

// File: rtl/serial_sub_fs.sv
// Combinational full subtractor: d = a - b - bin, bout = borrow out.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   a, b : minuend / subtrahend bits
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
module fs (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic hs1_d;
    logic hs1_b;
    logic hs2_b;

    // First half subtractor: a - b.
    assign hs1_d = a ^ b;
    assign hs1_b = ~a & b;

    // Second half subtractor: (a - b) - bin.
    assign d     = hs1_d ^ bin;
    assign hs2_b = ~hs1_d & bin;

    // A borrow can arise in either stage, never in both.
    assign bout  = hs1_b | hs2_b;

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor src1 - src2, LSB first, one bit per clock.
// Latency: done pulses in the cycle after accept edge + WIDTH; issue interval WIDTH+2.
// Backpressure: start is honoured only in IDLE; ignored while busy (no queuing).
//
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   start       : request; sampled with src1/src2 on the accepting edge
//   src1, src2  : minuend / subtrahend (WIDTH bits)
//   busy        : high in RUN and DONE
//   done        : one-cycle pulse, diff/borrow just updated
//   diff        : (src1 - src2) mod 2^WIDTH, held until next completion
//   borrow      : src1 < src2, held until next completion
module serial_sub
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    arith_state_e     state_q,  state_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic             bin_q,    bin_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             borrow_q, borrow_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic             fs_d;
    logic             fs_bout;
    logic [WIDTH-1:0] res_next;

    fs u_fs (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (bin_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // Result fills from the top so that after WIDTH shifts the first
    // (least significant) difference bit lands in bit 0.
    assign res_next = {fs_d, res_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_d    = res_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sr_d  = src1;
                    b_sr_d  = src2;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                res_d  = res_next;
                bin_d  = fs_bout;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // Publish on the last bit so outputs only move on completion.
                    diff_d   = res_next;
                    borrow_d = fs_bout;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_q    <= '0;
            bin_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_q    <= res_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: 8-bit directed/table cases and 4-bit exhaustive.
// Latency: n/a.
// Backpressure: n/a.
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] src1_8 = '0;
    logic [7:0] src2_8 = '0;
    logic       busy8, done8, borrow8;
    logic [7:0] diff8;

    logic       start4 = 1'b0;
    logic [3:0] src1_4 = '0;
    logic [3:0] src2_4 = '0;
    logic       busy4, done4, borrow4;
    logic [3:0] diff4;

    int n_chk  = 0;
    int n_fail = 0;
    int done_cnt8 = 0;
    int done_cnt4 = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       br;
    } r8_t;

    typedef struct packed {
        logic [3:0] d;
        logic       br;
    } r4_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       br;
    } vec_t;

    r8_t q8[$];
    r4_t q4[$];

    always #5 clk = ~clk;

    serial_sub #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start8),
        .src1   (src1_8),
        .src2   (src2_8),
        .busy   (busy8),
        .done   (done8),
        .diff   (diff8),
        .borrow (borrow8)
    );

    serial_sub #(.WIDTH(4)) dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start4),
        .src1   (src1_4),
        .src2   (src2_4),
        .busy   (busy4),
        .done   (done4),
        .diff   (diff4),
        .borrow (borrow4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboards: every done pops the oldest expected result.
    always @(negedge clk) begin
        r8_t r;
        if (rst_n && done8) begin
            done_cnt8++;
            if (q8.size() == 0) begin
                chk("unexpected_done8", 32'(done8), 32'd0);
            end else begin
                r = q8.pop_front();
                chk("diff8", 32'(diff8), 32'(r.d));
                chk("borrow8", 32'(borrow8), 32'(r.br));
            end
        end
    end

    always @(negedge clk) begin
        r4_t r;
        if (rst_n && done4) begin
            done_cnt4++;
            if (q4.size() == 0) begin
                chk("unexpected_done4", 32'(done4), 32'd0);
            end else begin
                r = q4.pop_front();
                chk("diff4", 32'(diff4), 32'(r.d));
                chk("borrow4", 32'(borrow4), 32'(r.br));
            end
        end
    end

    // Called at a falling edge with dut8 idle; returns one cycle later.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] d, input logic br);
        src1_8 = a;
        src2_8 = b;
        start8 = 1'b1;
        q8.push_back('{d: d, br: br});
        @(negedge clk);
        start8 = 1'b0;
    endtask

    // Waits for done8, then one more cycle so dut8 is idle again.
    task automatic wait_done8(input string nm);
        bit seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (done8) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) chk({nm, "_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
        chk({nm, "_idle_busy"}, 32'(busy8), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        int   nb;
        int   done_at;
        int   base;
        logic [7:0] a8, b8, d8;
        logic [3:0] a4, b4, d4;

        tbl[0] = '{a: 8'hFF, b: 8'h00, d: 8'hFF, br: 1'b0};
        tbl[1] = '{a: 8'h80, b: 8'hFF, d: 8'h81, br: 1'b1};
        tbl[2] = '{a: 8'h10, b: 8'h20, d: 8'hF0, br: 1'b1};
        tbl[3] = '{a: 8'hC8, b: 8'h64, d: 8'h64, br: 1'b0};
        tbl[4] = '{a: 8'h01, b: 8'h00, d: 8'h01, br: 1'b0};
        tbl[5] = '{a: 8'h00, b: 8'hFF, d: 8'h01, br: 1'b1};
        tbl[6] = '{a: 8'h7F, b: 8'h80, d: 8'hFF, br: 1'b1};
        tbl[7] = '{a: 8'hFE, b: 8'hFF, d: 8'hFF, br: 1'b1};

        // Reset.
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_done8", 32'(done8), 32'd0);
        chk("rst_diff8", 32'(diff8), 32'd0);
        chk("rst_borrow8", 32'(borrow8), 32'd0);
        chk("rst_busy4", 32'(busy4), 32'd0);
        chk("rst_diff4", 32'(diff4), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: latency and busy width.
        issue8(8'd100, 8'd37, 8'd63, 1'b0);
        nb = 0;
        done_at = -1;
        for (int k = 1; k <= 12; k++) begin
            if (busy8) nb++;
            if (done8 && done_at < 0) done_at = k;
            @(negedge clk);
        end
        chk("t1_busy_cycles", 32'(nb), 32'd9);
        chk("t1_done_cycle", 32'(done_at), 32'd9);

        // Test 2: borrow wrap, then equal operands; outputs hold meanwhile.
        issue8(8'h00, 8'h01, 8'hFF, 1'b1);
        wait_done8("t2a");
        issue8(8'hA5, 8'hA5, 8'h00, 1'b0);
        chk("t2_hold_diff", 32'(diff8), 32'hFF);
        chk("t2_hold_borrow", 32'(borrow8), 32'd1);
        repeat (4) @(negedge clk);
        chk("t2_hold_diff_mid", 32'(diff8), 32'hFF);
        wait_done8("t2b");

        // Table-driven vectors.
        for (int i = 0; i < 8; i++) begin
            issue8(tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].br);
            wait_done8("tbl");
        end

        // Test 3: start held high, operands change every cycle; acceptances
        // land every WIDTH+2 = 10 edges.
        base = done_cnt8;
        for (int k = 0; k < 25; k++) begin
            a8 = 8'(k * 37 + 11);
            b8 = 8'(k * 91 + 200);
            src1_8 = a8;
            src2_8 = b8;
            start8 = 1'b1;
            if (k % 10 == 0) begin
                d8 = a8 - b8;
                q8.push_back('{d: d8, br: (a8 < b8)});
            end
            @(negedge clk);
        end
        start8 = 1'b0;
        repeat (15) @(negedge clk);
        chk("t3_done_count", 32'(done_cnt8 - base), 32'd3);
        chk("t3_queue_empty", 32'(q8.size()), 32'd0);

        // Test 4: reset after 3 RUN cycles aborts without a done pulse.
        base = done_cnt8;
        src1_8 = 8'h33;
        src2_8 = 8'h11;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t4_busy", 32'(busy8), 32'd0);
        chk("t4_done", 32'(done8), 32'd0);
        chk("t4_diff", 32'(diff8), 32'd0);
        chk("t4_borrow", 32'(borrow8), 32'd0);
        repeat (15) @(negedge clk);
        chk("t4_no_done", 32'(done_cnt8 - base), 32'd0);
        issue8(8'd5, 8'd9, 8'hFC, 1'b1);
        wait_done8("t4b");

        // Test 5: WIDTH=4 exhaustive, back-to-back every 6 edges; off-slot
        // cycles present junk operands that must be ignored.
        base = done_cnt4;
        for (int k = 0; k < 256 * 6; k++) begin
            if (k % 6 == 0) begin
                a4 = 4'((k / 6) >> 4);
                b4 = 4'(k / 6);
                d4 = a4 - b4;
                q4.push_back('{d: d4, br: (a4 < b4)});
            end else begin
                a4 = 4'(k * 5 + 3);
                b4 = 4'(k * 11 + 7);
            end
            src1_4 = a4;
            src2_4 = b4;
            start4 = 1'b1;
            @(negedge clk);
        end
        start4 = 1'b0;
        repeat (12) @(negedge clk);
        chk("t5_done_count", 32'(done_cnt4 - base), 32'd256);
        chk("t5_queue_empty", 32'(q4.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
